// File: rtl/banked_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : banked_mem_pkg
// Purpose  : Shared constants, types and helpers for the four-bank,
//            word-interleaved main-memory model.
// Contents : NUM_BANKS, default bank occupancy / read latency, bank FSM
//            state type, counter-width helper, bank_of() bank selector.
// Revision : 1.0 - initial release
// ============================================================================
package banked_mem_pkg;

  localparam int NUM_BANKS    = 4;
  localparam int BANK_CYC_DEF = 4;
  localparam int RD_LAT_DEF   = 2;

  // Counter width for a bank occupancy of cyc cycles. A single-cycle
  // occupancy still gets a 1-bit counter so the vector is never zero-width.
  function automatic int cnt_width(input int cyc);
    return (cyc > 1) ? $clog2(cyc) : 1;
  endfunction

  localparam int CNT_W = cnt_width(BANK_CYC_DEF);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } bank_st_t;

  // Words are interleaved across banks, so the bank is the word address LSBs
  // (byte address bits 2:1).
  function automatic logic [1:0] bank_of(input logic [2:1] addr);
    return addr[2:1];
  endfunction

endpackage : banked_mem_pkg
`default_nettype wire

// File: rtl/banked_mem_if.sv
`default_nettype none
// ============================================================================
// Module   : banked_mem_if
// Purpose  : Single-port request/response bundle between the cache
//            controller (master) and the banked memory (slave).
// Signals  : addr, data_in, wr, rd        - request (master -> slave)
//            data_out, rd_valid           - read return (slave -> master)
//            stall, err, busy[NUM_BANKS]  - status (slave -> master)
// Revision : 1.0 - initial release
// ============================================================================
interface banked_mem_if
  import banked_mem_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);

  logic [ADDR_W-1:0]    addr;
  logic [DATA_W-1:0]    data_in;
  logic                 wr;
  logic                 rd;
  logic [DATA_W-1:0]    data_out;
  logic                 rd_valid;
  logic                 stall;
  logic                 err;
  logic [NUM_BANKS-1:0] busy;

  modport master (
    output addr, data_in, wr, rd,
    input  data_out, rd_valid, stall, err, busy
  );

  modport slave (
    input  addr, data_in, wr, rd,
    output data_out, rd_valid, stall, err, busy
  );

endinterface : banked_mem_if
`default_nettype wire

// File: rtl/banked_mem_bank_timer.sv
`default_nettype none
// ============================================================================
// Module   : bank_timer
// Purpose  : Occupancy tracker for one memory bank. A load starts a
//            BANK_CYC-cycle busy window (the load cycle included).
// Ports    : clk    - system clock
//            rst_n  - asynchronous active-low reset
//            i_load - request accepted to this bank this cycle
//            o_busy - bank occupied (registered)
// Revision : 1.0 - initial release
// ============================================================================
module bank_timer
  import banked_mem_pkg::*;
#(
  parameter int BANK_CYC = BANK_CYC_DEF
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic i_load,
  output logic      o_busy
);

  localparam int              c_CNT_W = cnt_width(BANK_CYC);
  localparam logic [c_CNT_W-1:0] c_LOAD  = c_CNT_W'(BANK_CYC - 1);
  localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

  bank_st_t           r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_busy;

  // busy is kept as its own register so it equals (cnt != 0) without a
  // compare on the output path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // A one-cycle occupancy never leaves IDLE.
          if (i_load && (c_LOAD != '0)) begin
            r_state <= ST_BUSY;
            r_cnt   <= c_LOAD;
            r_busy  <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (r_cnt > c_ONE) begin
            r_cnt <= r_cnt - c_ONE;
          end else begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy = r_busy;

endmodule : bank_timer
`default_nettype wire

// File: rtl/banked_mem.sv
`default_nettype none
// ============================================================================
// Module   : banked_mem
// Purpose  : Four-bank word-interleaved main memory behind the cache
//            controller. Single request port, per-bank occupancy, same-cycle
//            stall on a busy bank, fixed-latency read return.
// Ports    : clk        - system clock
//            rst_n      - asynchronous active-low reset
//            bus.slave  - addr/data_in/wr/rd in; data_out/rd_valid/stall/
//                         err/busy out (see banked_mem_if)
// Revision : 1.0 - initial release
// ============================================================================
module banked_mem
  import banked_mem_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int BANK_CYC = BANK_CYC_DEF,
  parameter int RD_LAT   = RD_LAT_DEF
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  banked_mem_if.slave bus
);

  localparam int c_DEPTH = 1 << (ADDR_W - 1);

  logic [NUM_BANKS-1:0] w_busy;
  logic [1:0]           w_bank;
  logic [ADDR_W-2:0]    w_word;
  logic                 w_req;
  logic                 w_illegal;
  logic                 w_accept;
  logic                 w_acc_rd;

  // Storage is deliberately not reset: committed writes survive reset.
  logic [DATA_W-1:0]    r_mem [c_DEPTH];
  logic [RD_LAT-1:0]    r_vld;
  logic [DATA_W-1:0]    r_dat [RD_LAT];

  assign w_bank    = bank_of(bus.addr[2:1]);
  assign w_word    = bus.addr[ADDR_W-1:1];
  assign w_req     = bus.rd | bus.wr;
  assign w_illegal = w_req & ((bus.rd & bus.wr) | bus.addr[0]);

  // Illegal requests are dropped outright, so they never stall and never
  // reach a bank. Everything is gated by rst_n so the status lines and the
  // storage stay quiet while reset is held.
  assign w_accept  = rst_n & w_req & ~w_illegal & ~w_busy[w_bank];
  assign w_acc_rd  = w_accept & bus.rd;

  assign bus.err   = rst_n & w_illegal;
  assign bus.stall = rst_n & w_req & ~w_illegal & w_busy[w_bank];
  assign bus.busy  = w_busy;

  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    bank_timer #(
      .BANK_CYC (BANK_CYC)
    ) u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_load (w_accept && (w_bank == 2'(gi))),
      .o_busy (w_busy[gi])
    );
  end

  always_ff @(posedge clk) begin
    if (w_accept && bus.wr) begin
      r_mem[w_word] <= bus.data_in;
    end
  end

  // Data side of the read pipe: the word is sampled at accept and then
  // shifted; only the valid side needs reset.
  always_ff @(posedge clk) begin
    r_dat[0] <= r_mem[w_word];
    for (int i = 1; i < RD_LAT; i++) begin
      r_dat[i] <= r_dat[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= w_acc_rd;
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
      end
    end
  end

  assign bus.rd_valid = r_vld[RD_LAT-1];
  assign bus.data_out = r_vld[RD_LAT-1] ? r_dat[RD_LAT-1] : '0;

endmodule : banked_mem
`default_nettype wire
